// File: rtl/shift_chain_pkg.sv
// Shared types for the shift-chain arbiter: FSM states,
// the tagged chain-stage bundle and default sizes.
package shift_chain_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_LEN_W = 8;

  // wide enough for the largest supported requester count (16)
  localparam int OWN_MAX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_e;

  typedef struct packed {
    logic                 data;
    logic                 valid;
    logic                 last;
    logic [OWN_MAX_W-1:0] owner;
  } stage_t;

endpackage

// File: rtl/shift_chain_arbiter_if.sv
// Requester/stream bundle between serial producers
// and the shift-chain arbiter.
interface shift_chain_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
);

  localparam int OWN_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ-1:0]       req_data;
  logic [N_REQ-1:0]       grant;
  logic                   data_rd;
  logic                   out_data;
  logic                   out_valid;
  logic                   out_last;
  logic [OWN_W-1:0]       out_owner;
  logic                   busy;

  modport master (
    output req,
    output req_len,
    output req_data,
    input  grant,
    input  data_rd,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_owner,
    input  busy
  );

  modport slave (
    input  req,
    input  req_len,
    input  req_data,
    output grant,
    output data_rd,
    output out_data,
    output out_valid,
    output out_last,
    output out_owner,
    output busy
  );

endinterface

// File: rtl/delay_chain_tagged.sv
// DEPTH-stage shift register carrying data bits together
// with their valid/last/owner tags.
module delay_chain_tagged
  import shift_chain_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic   CLK,
  input  logic   RST,
  input  stage_t i_stage,
  output stage_t o_stage
);

  stage_t r_stg [DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stg[i] <= '0;
      end
    end else begin
      r_stg[0] <= i_stage;
      for (int i = 1; i < DEPTH; i++) begin
        r_stg[i] <= r_stg[i-1];
      end
    end
  end

  assign o_stage = r_stg[DEPTH-1];

endmodule

// File: rtl/shift_chain_arbiter.sv
// Round-robin arbiter that streams one requester's burst at a
// time through a shared tagged delay chain, flushing between bursts.
module shift_chain_arbiter
  import shift_chain_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input logic                  CLK,
  input logic                  RST,
  shift_chain_arbiter_if.slave bus
);

  localparam int OWN_W  = $clog2(N_REQ);
  localparam int IDX_W  = OWN_W + 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);

  state_e            r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [OWN_W-1:0]  r_owner;
  logic [OWN_W-1:0]  r_rr;
  logic [LEN_W-1:0]  r_cnt;
  logic [FCNT_W-1:0] r_fcnt;

  logic [LEN_W-1:0]  w_len [N_REQ];
  logic [N_REQ-1:0]  w_elig;
  logic              w_found;
  logic [OWN_W-1:0]  w_win;
  logic [OWN_W-1:0]  w_rr_nxt;
  logic [IDX_W-1:0]  w_idx;
  logic [N_REQ-1:0]  w_onehot;
  logic              w_arb;
  logic              w_last_bit;
  stage_t            w_stage_in;
  stage_t            w_stage_out;
  logic              w_unused_owner;

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign w_len[g]  = bus.req_len[g*LEN_W +: LEN_W];
    assign w_elig[g] = bus.req[g] && (w_len[g] != '0);
  end

  // first eligible index at or after the rr pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = IDX_W'(r_rr) + IDX_W'(i);
      if (w_idx >= IDX_W'(N_REQ)) begin
        w_idx = w_idx - IDX_W'(N_REQ);
      end
      if (!w_found && w_elig[w_idx[OWN_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[OWN_W-1:0];
      end
    end
  end

  assign w_rr_nxt = (w_win == OWN_W'(N_REQ - 1)) ?
                    '0 : w_win + OWN_W'(1);
  assign w_onehot = N_REQ'(1) << w_win;

  assign w_arb = (r_state == IDLE) ||
                 ((r_state == FLUSH) && (r_fcnt == '0));

  assign w_last_bit = (r_cnt == LEN_W'(1));

  always_comb begin
    w_stage_in = '0;
    if (r_state == STREAM) begin
      w_stage_in.data  = bus.req_data[r_owner];
      w_stage_in.valid = 1'b1;
      w_stage_in.last  = w_last_bit;
      w_stage_in.owner = OWN_MAX_W'(r_owner);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
    end else if (w_arb && w_found) begin
      r_state <= STREAM;
      r_grant <= w_onehot;
      r_owner <= w_win;
      r_cnt   <= w_len[w_win];
      r_rr    <= w_rr_nxt;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_grant <= '0;
        end
        STREAM: begin
          r_cnt <= r_cnt - LEN_W'(1);
          if (w_last_bit) begin
            r_state <= FLUSH;
            r_fcnt  <= FCNT_W'(DEPTH - 1);
          end
        end
        FLUSH: begin
          if (r_fcnt == '0) begin
            r_state <= IDLE;
            r_grant <= '0;
          end else begin
            r_fcnt <= r_fcnt - FCNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  delay_chain_tagged #(
    .DEPTH(DEPTH)
  ) u_chain (
    .CLK    (CLK),
    .RST    (RST),
    .i_stage(w_stage_in),
    .o_stage(w_stage_out)
  );

  assign bus.grant     = r_grant;
  assign bus.data_rd   = (r_state == STREAM);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_data  = w_stage_out.data;
  assign bus.out_valid = w_stage_out.valid;
  assign bus.out_last  = w_stage_out.last;
  assign bus.out_owner = w_stage_out.owner[OWN_W-1:0];

  assign w_unused_owner = ^w_stage_out.owner;

endmodule

// File: tb/tb_shift_chain_arbiter.sv
// Randomised bench for shift_chain_arbiter against a
// burst-schedule reference model.
module tb_shift_chain_arbiter;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int LW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  shift_chain_arbiter_if #(.N_REQ(N), .LEN_W(LW)) bus ();

  shift_chain_arbiter #(
    .N_REQ(N),
    .DEPTH(D),
    .LEN_W(LW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit d;
    bit l;
    int o;
  } ev_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_v = 0;
  int n_l = 0;

  logic [N-1:0]    t_req;
  logic [N*LW-1:0] t_len;

  // model: current burst window, rr pointer, next arbitration cycle
  int  m_rr;
  int  m_st;
  int  m_len;
  int  m_own;
  int  m_free;
  ev_t m_out [int];

  task automatic expect_eq(string tag, logic [31:0] got,
                           logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    int c = cyc;
    bit busy_e;
    bit rd_e;
    busy_e = (m_len > 0) && (c >= m_st) && (c < m_st + m_len + D);
    rd_e   = (m_len > 0) && (c >= m_st) && (c < m_st + m_len);
    expect_eq("busy", 32'(bus.busy), 32'(busy_e));
    expect_eq("data_rd", 32'(bus.data_rd), 32'(rd_e));
    expect_eq("grant", 32'(bus.grant), busy_e ? (32'd1 << m_own) : 32'd0);
    expect_eq("out_valid", 32'(bus.out_valid), 32'(m_out.exists(c)));
    if (m_out.exists(c)) begin
      expect_eq("out_data", 32'(bus.out_data), 32'(m_out[c].d));
      expect_eq("out_last", 32'(bus.out_last), 32'(m_out[c].l));
      expect_eq("out_owner", 32'(bus.out_owner), m_out[c].o);
      m_out.delete(c);
    end
    if (bus.out_valid === 1'b1) n_v++;
    if (bus.out_valid === 1'b1 && bus.out_last === 1'b1) n_l++;
    if (rd_e) begin
      m_out[c + D] = '{bus.req_data[m_own], (c == m_st + m_len - 1), m_own};
    end
    if (c == m_free) begin
      int win = -1;
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (win < 0 && bus.req[i] && bus.req_len[i*LW +: LW] != 0) win = i;
      end
      if (win >= 0) begin
        m_st   = c + 1;
        m_len  = int'(bus.req_len[win*LW +: LW]);
        m_own  = win;
        m_rr   = (win + 1) % N;
        m_free = c + m_len + D;
      end else begin
        m_free = c + 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    cyc++;
    #1;
    bus.req      = t_req;
    bus.req_len  = t_len;
    bus.req_data = N'($urandom);
    @(negedge CLK);
    model_step();
  endtask

  task automatic do_reset(int hold);
    @(posedge CLK);
    cyc++;
    #1;
    RST = 1'b0;
    #1;
    expect_eq("rst_grant", 32'(bus.grant), 0);
    expect_eq("rst_busy", 32'(bus.busy), 0);
    expect_eq("rst_data_rd", 32'(bus.data_rd), 0);
    expect_eq("rst_out_valid", 32'(bus.out_valid), 0);
    expect_eq("rst_out_data", 32'(bus.out_data), 0);
    expect_eq("rst_out_last", 32'(bus.out_last), 0);
    expect_eq("rst_out_owner", 32'(bus.out_owner), 0);
    repeat (hold) begin
      @(posedge CLK);
      cyc++;
      #1;
      expect_eq("rst_hold_valid", 32'(bus.out_valid), 0);
    end
    @(posedge CLK);
    cyc++;
    #1;
    RST          = 1'b1;
    bus.req      = t_req;
    bus.req_len  = t_len;
    bus.req_data = N'($urandom);
    m_out.delete();
    m_rr   = 0;
    m_len  = 0;
    m_st   = -1000;
    m_free = cyc;
    @(negedge CLK);
    model_step();
  endtask

  initial begin
    bit hit;
    t_req        = '0;
    t_len        = '0;
    bus.req      = '0;
    bus.req_len  = '0;
    bus.req_data = '0;
    m_rr   = 0;
    m_len  = 0;
    m_st   = -1000;
    m_free = 0;

    do_reset(2);
    repeat (3) cycle();

    // single burst from requester 1
    t_req = 4'b0010;
    t_len[1*LW +: LW] = 8'd3;
    cycle();
    t_req = '0;
    repeat (12) cycle();

    // full contention, length 2 each
    t_req = 4'b1111;
    for (int k = 0; k < N; k++) t_len[k*LW +: LW] = 8'd2;
    repeat (32) cycle();
    t_req = '0;
    repeat (10) cycle();

    // zero-length requests are never granted
    t_req = 4'b1100;
    t_len = '0;
    t_len[3*LW +: LW] = 8'd1;
    repeat (12) cycle();
    t_len[3*LW +: LW] = 8'd0;
    repeat (10) cycle();
    t_req = '0;
    repeat (2) cycle();

    // owner drops req in its second stream cycle
    t_req = 4'b0001;
    t_len[0*LW +: LW] = 8'd5;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      cycle();
      if (m_len > 0 && cyc == m_st) hit = 1'b1;
    end
    expect_eq("drop_grant_seen", 32'(hit), 1);
    t_req = '0;
    repeat (14) cycle();

    // async reset in the second flush cycle
    t_req = 4'b1111;
    for (int k = 0; k < N; k++) t_len[k*LW +: LW] = 8'd3;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      cycle();
      if (m_len > 0 && cyc == m_st + m_len) hit = 1'b1;
    end
    expect_eq("flush_reached", 32'(hit), 1);
    do_reset(2);
    cycle();
    expect_eq("rst_regrant", 32'(bus.grant), 32'h1);
    t_req = '0;
    repeat (14) cycle();

    // maximum length burst
    t_req = 4'b0100;
    t_len = '0;
    t_len[2*LW +: LW] = 8'd255;
    n_v = 0;
    n_l = 0;
    cycle();
    t_req = '0;
    repeat (265) cycle();
    expect_eq("max_valid_cnt", 32'(n_v), 255);
    expect_eq("max_last_cnt", 32'(n_l), 1);

    // random traffic
    repeat (1500) begin
      if ($urandom_range(7) == 0) begin
        t_req = N'($urandom);
        for (int k = 0; k < N; k++) begin
          t_len[k*LW +: LW] = LW'($urandom_range(6));
        end
      end
      cycle();
    end
    t_req = '0;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
